// File: rtl/btn_pkg.sv
// Shared types and defaults for the button event decoder.
// Optional auto-repeat is enabled in the top by defining BTN_AUTOREPEAT_EN.
package btn_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE    = 2'd0,
    BTN_PRESSED = 2'd1,
    BTN_LONG    = 2'd2
  } btn_state_t;

  localparam int BTN_LONG_DEF   = 25_000_000;
  localparam int BTN_REPEAT_DEF = 5_000_000;

  // Hold counter must be able to reach the larger of the two thresholds.
  function automatic int btn_cnt_width(input int long_cycles, input int repeat_cycles);
    int m;
    m = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Purpose: one-cycle delay of the debounced level plus rise/fall decode.
// Latency: rise/fall are combinational against the previous sample.
// Backpressure: none; db_q resets to 1 so a button held through reset is not a press.
module btn_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic db_in,
  output logic rise,
  output logic fall
);

  logic db_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      db_q <= 1'b1;
    end else begin
      db_q <= db_in;
    end
  end

  assign rise = db_in & ~db_q;
  assign fall = ~db_in & db_q;

endmodule

// File: rtl/button_event_decoder.sv
// Purpose: turns a debounced button level into press/release/short/long/repeat UI strobes.
// Latency: every output is registered, one cycle after the sampling edge; no backpressure.
// Build option: define BTN_AUTOREPEAT_EN for periodic repeat_pulse while a long press is held.
module button_event_decoder
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES   = BTN_LONG_DEF,
  parameter int REPEAT_CYCLES = BTN_REPEAT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       db_in,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_press,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_cnt
);

  localparam int CNT_W = btn_cnt_width(LONG_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES);
`endif

  btn_state_t       state;
  logic [CNT_W-1:0] hold_cnt;
  logic             rise;
  logic             fall;

  btn_edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .db_in (db_in),
    .rise  (rise),
    .fall  (fall)
  );

`ifdef BTN_AUTOREPEAT_EN
  logic repeat_q;
  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  // Outside BTN_IDLE the previous sample is always 1, so fall equals a low db_in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= BTN_IDLE;
      hold_cnt      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      held          <= 1'b0;
      press_cnt     <= 8'd0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_q      <= 1'b0;
`endif
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_q      <= 1'b0;
`endif
      case (state)
        BTN_IDLE: begin
          if (rise) begin
            press_pulse <= 1'b1;
            press_cnt   <= press_cnt + 8'd1;
            hold_cnt    <= CNT_ONE;
            held        <= 1'b1;
            state       <= BTN_PRESSED;
          end
        end
        BTN_PRESSED: begin
          if (fall) begin
            release_pulse <= 1'b1;
            short_press   <= 1'b1;
            hold_cnt      <= '0;
            held          <= 1'b0;
            state         <= BTN_IDLE;
          end else if (hold_cnt == LONG_LAST) begin
            long_press <= 1'b1;
            hold_cnt   <= CNT_ONE;
            state      <= BTN_LONG;
          end else begin
            hold_cnt <= hold_cnt + CNT_ONE;
          end
        end
        BTN_LONG: begin
          if (fall) begin
            release_pulse <= 1'b1;
            hold_cnt      <= '0;
            held          <= 1'b0;
            state         <= BTN_IDLE;
`ifdef BTN_AUTOREPEAT_EN
          end else if (hold_cnt == REPEAT_LAST) begin
            repeat_q <= 1'b1;
            hold_cnt <= CNT_ONE;
          end else begin
            hold_cnt <= hold_cnt + CNT_ONE;
          end
`else
          end else if (~&hold_cnt) begin
            hold_cnt <= hold_cnt + CNT_ONE;
          end
`endif
        end
        default: begin
          hold_cnt <= '0;
          held     <= 1'b0;
          state    <= BTN_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Expected strobe events are queued at stimulus time and matched as the DUT emits them.
module tb_button_event_decoder;

  localparam int LONG = 8;
  localparam int REP  = 4;

  localparam logic [4:0] M_PRESS     = 5'b10000;
  localparam logic [4:0] M_REL_SHORT = 5'b01100;
  localparam logic [4:0] M_REL       = 5'b01000;
  localparam logic [4:0] M_LONG      = 5'b00010;
  localparam logic [4:0] M_REP       = 5'b00001;

  typedef struct packed {
    logic [31:0] cyc;
    logic [4:0]  mask;
    logic [7:0]  cnt;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       db_in;
  logic       press_pulse, release_pulse, short_press, long_press, repeat_pulse, held;
  logic [7:0] press_cnt;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt;
  ev_t        exp_q[$];

  button_event_decoder #(
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (REP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .db_in         (db_in),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_press   (short_press),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .held          (held),
    .press_cnt     (press_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Any nonzero strobe vector must match the oldest expected event exactly.
  always @(negedge clk) begin
    logic [4:0] m;
    ev_t        obs;
    ev_t        exp_e;
    m = {press_pulse, release_pulse, short_press, long_press, repeat_pulse};
    if (m !== 5'b0) begin
      obs.cyc  = cyc;
      obs.mask = m;
      obs.cnt  = press_cnt;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_event cyc=%0d observed mask=%b expected no event", cyc, m);
      end
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        assert (obs === exp_e) else begin
          errors++;
          $error("FAIL event observed cyc=%0d mask=%b cnt=%0d expected cyc=%0d mask=%b cnt=%0d",
                 obs.cyc, obs.mask, obs.cnt, exp_e.cyc, exp_e.mask, exp_e.cnt);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_ev(input int c, input logic [4:0] m);
    ev_t e;
    e.cyc  = c;
    e.mask = m;
    e.cnt  = exp_cnt;
    exp_q.push_back(e);
  endtask

  // Hold db_in high for h sampling edges, then low for gap edges.
  task automatic press_hold(input int h, input int gap);
    int e0;
    e0 = cyc + 1;
    db_in = 1'b1;
    exp_cnt = exp_cnt + 8'd1;
    push_ev(e0, M_PRESS);
    if (h <= LONG) begin
      push_ev(e0 + h, M_REL_SHORT);
    end else begin
      push_ev(e0 + LONG, M_LONG);
`ifdef BTN_AUTOREPEAT_EN
      for (int k = 1; LONG + k * REP <= h - 1; k++) push_ev(e0 + LONG + k * REP, M_REP);
`endif
      push_ev(e0 + h, M_REL);
    end
    step();
    chk("held_during_press", {31'd0, held}, 32'd1);
    repeat (h - 1) step();
    db_in = 1'b0;
    repeat (gap) step();
    chk("held_after_release", {31'd0, held}, 32'd0);
  endtask

  initial begin
    int e0;
    reset   = 1'b1;
    db_in   = 1'b0;
    exp_cnt = 8'd0;
    repeat (3) step();
    chk("rst_strobes", {27'd0, press_pulse, release_pulse, short_press, long_press, repeat_pulse}, 32'd0);
    chk("rst_held", {31'd0, held}, 32'd0);
    chk("rst_press_cnt", {24'd0, press_cnt}, 32'd0);
    reset = 1'b0;
    repeat (6) step();

    // Short press, then both sides of the long threshold.
    press_hold(3, 4);
    chk("short_press_cnt", {24'd0, press_cnt}, 32'd1);
    press_hold(LONG, 3);
    press_hold(LONG + 1, 3);
    chk("boundary_press_cnt", {24'd0, press_cnt}, 32'd3);

    // Re-press on the cycle right after release.
    press_hold(2, 1);
    press_hold(2, 3);

    // Long hold: repeats only with auto-repeat built in.
    press_hold(30, 4);
    chk("long_hold_press_cnt", {24'd0, press_cnt}, 32'd6);

    // Button held through reset gives nothing until released and pressed again.
    db_in   = 1'b1;
    reset   = 1'b1;
    exp_cnt = 8'd0;
    repeat (5) step();
    reset = 1'b0;
    chk("held_thru_rst_cnt", {24'd0, press_cnt}, 32'd0);
    repeat (6) step();
    chk("held_thru_rst_held", {31'd0, held}, 32'd0);
    db_in = 1'b0;
    repeat (3) step();
    press_hold(3, 3);
    chk("repress_after_rst_cnt", {24'd0, press_cnt}, 32'd1);

    // 256 one-edge glitches wrap the counter back to 0.
    reset   = 1'b1;
    exp_cnt = 8'd0;
    repeat (2) step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 256; i++) begin
      press_hold(1, 1);
      if (i == 254) chk("wrap_cnt_255", {24'd0, press_cnt}, 32'd255);
    end
    chk("wrap_cnt_0", {24'd0, press_cnt}, 32'd0);
    repeat (2) step();

    // Reset five edges into a hold aborts silently.
    e0 = cyc + 1;
    db_in = 1'b1;
    exp_cnt = exp_cnt + 8'd1;
    push_ev(e0, M_PRESS);
    repeat (5) step();
    reset = 1'b1;
    step();
    chk("midhold_rst_strobes", {27'd0, press_pulse, release_pulse, short_press, long_press, repeat_pulse}, 32'd0);
    chk("midhold_rst_held", {31'd0, held}, 32'd0);
    chk("midhold_rst_cnt", {24'd0, press_cnt}, 32'd0);
    exp_cnt = 8'd0;
    repeat (2) step();
    reset = 1'b0;
    repeat (12) step();
    chk("midhold_after_held", {31'd0, held}, 32'd0);
    db_in = 1'b0;
    repeat (4) step();
    chk("midhold_release_held", {31'd0, held}, 32'd0);

    repeat (3) step();
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL pending_events observed=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
